inst_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 16-bit core.
- Owns the program counter and the 32-bit instruction register.
- Drives synchronous-read addresses to the instruction memory and issues one execute strobe per instruction to the register/ALU datapath.
- Resolves jumps from the datapath's condition flag and stops on the halt opcode.
- Sits between `inst_mem` and the datapath inside `top`, replacing the free-running per-cycle PC update.

---
 rtl/proc_pkg.sv | 43 ++++
 rtl/settle_counter.sv | 27 ++
 rtl/inst_sequencer.sv | 119 +++++++++++
 tb/tb_inst_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit core: opcode field, opcodes, sequencer states.
package proc_pkg;

   localparam int unsigned OPC_MSB   = 31;
   localparam int unsigned OPC_LSB   = 27;
   localparam int unsigned OPC_W     = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned OPERAND_W = INSTR_W - OPC_W;

   typedef logic [OPC_W-1:0] opcode_t;

   localparam opcode_t OP_NOP  = 5'b00000;
   localparam opcode_t OP_ADD  = 5'b00001;
   localparam opcode_t OP_SUB  = 5'b00010;
   localparam opcode_t OP_AND  = 5'b00011;
   localparam opcode_t OP_OR   = 5'b00100;
   localparam opcode_t OP_XOR  = 5'b00101;
   localparam opcode_t OP_LDI  = 5'b00110;
   localparam opcode_t OP_CMP  = 5'b00111;
   localparam opcode_t OP_JMP  = 5'b01000;
   localparam opcode_t OP_HALT = 5'b11011;

   typedef struct packed {
      opcode_t              opc;
      logic [OPERAND_W-1:0] operand;
   } instr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WAIT,
      ST_NEXT,
      ST_HALT
   } seq_state_e;

   function automatic logic [INSTR_W-1:0] mk_instr(input opcode_t opc,
                                                   input logic [OPERAND_W-1:0] operand);
      return {opc, operand};
   endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag; times the post-execute settle window.
module settle_counter #(
   parameter int unsigned CW = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          zero_c
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns pc and ir, strobes the datapath
// once per instruction, resolves jumps in NEXT and stops on the halt opcode.
module inst_sequencer
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       ir,
   output logic              exec_en,
   input  logic              jump_take,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   localparam int unsigned CW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned LOAD_V = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
   localparam seq_state_e  AFTER_EXEC = (SETTLE_CYC > 0) ? ST_WAIT : ST_NEXT;

   seq_state_e        state_q;
   logic [ADDR_W-1:0] pc_q;
   instr_t            ir_q;
   logic              exec_q;
   logic              busy_q;
   logic              halted_q;
   logic [CNT_W-1:0]  retired_q;
   logic              wait_zero_c;

   settle_counter #(
      .CW(CW)
   ) u_settle (
      .clk_i      (clk),
      .rst_i      (sys_rst),
      .load_i     (state_q == ST_EXEC),
      .load_val_i (CW'(LOAD_V)),
      .dec_i      (state_q == ST_WAIT),
      .zero_c     (wait_zero_c)
   );

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         exec_q    <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         exec_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state_q   <= ST_FETCH;
                  pc_q      <= '0;
                  retired_q <= '0;
                  busy_q    <= 1'b1;
                  halted_q  <= 1'b0;
               end
            end
            ST_FETCH: begin
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               ir_q    <= imem_rdata;
               exec_q  <= 1'b1;
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               state_q <= AFTER_EXEC;
            end
            ST_WAIT: begin
               if (wait_zero_c) begin
                  state_q <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (retired_q != '1) begin
                  retired_q <= retired_q + CNT_W'(1);
               end
               // Halt wins over a taken jump; pc is left on the halt word.
               if (ir_q.opc == OP_HALT) begin
                  state_q  <= ST_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= ST_FETCH;
                  if (jump_take) begin
                     pc_q <= ir_q.operand[ADDR_W-1:0];
                  end else begin
                     pc_q <= pc_q + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // pc is itself a register, so the memory address stays registered and equal to pc.
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign exec_en   = exec_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: default build plus a small build with
// ADDR_W=3, SETTLE_CYC=0, CNT_W=3 for wrap, short period and saturation.
module tb_inst_sequencer;
   import proc_pkg::*;

   logic clk = 1'b0;
   logic sys_rst;
   always #5 clk = ~clk;

   // default instance
   logic        start_a;
   logic [4:0]  addr_a, pc_a;
   logic [31:0] rdata_a, ir_a;
   logic        exec_a, busy_a, halted_a;
   logic [15:0] retired_a;
   logic [31:0] jt_mask_a;
   logic        jump_a;
   logic [31:0] mem_a [32];

   // small instance
   logic        start_b;
   logic [2:0]  addr_b, pc_b;
   logic [31:0] rdata_b, ir_b;
   logic        exec_b, busy_b, halted_b;
   logic [2:0]  retired_b;
   logic        jump_b;
   logic [31:0] mem_b [8];

   assign jump_a = jt_mask_a[pc_a];
   assign jump_b = 1'b0;

   always @(posedge clk) rdata_a <= mem_a[addr_a];
   always @(posedge clk) rdata_b <= mem_b[addr_b];

   inst_sequencer #(.ADDR_W(5), .SETTLE_CYC(4), .CNT_W(16)) dut_a (
      .clk(clk), .sys_rst(sys_rst), .start(start_a), .imem_addr(addr_a),
      .imem_rdata(rdata_a), .ir(ir_a), .exec_en(exec_a), .jump_take(jump_a),
      .pc(pc_a), .busy(busy_a), .halted(halted_a), .retired(retired_a));

   inst_sequencer #(.ADDR_W(3), .SETTLE_CYC(0), .CNT_W(3)) dut_b (
      .clk(clk), .sys_rst(sys_rst), .start(start_b), .imem_addr(addr_b),
      .imem_rdata(rdata_b), .ir(ir_b), .exec_en(exec_b), .jump_take(jump_b),
      .pc(pc_b), .busy(busy_b), .halted(halted_b), .retired(retired_b));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // results of the last run_a call
   int         n_ex, min_gap, max_gap;
   logic [4:0] ex_pc [8];

   task automatic pulse_start_a();
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
   endtask

   task automatic run_a(input int budget, output bit done);
      int last;
      last = 0; n_ex = 0; min_gap = 1000; max_gap = 0; done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (exec_a) begin
            if (n_ex > 0) begin
               if (c - last < min_gap) min_gap = c - last;
               if (c - last > max_gap) max_gap = c - last;
            end
            if (n_ex < 8) ex_pc[n_ex] = pc_a;
            n_ex++;
            last = c;
         end
         if (halted_a) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic load_straight();
      for (int i = 0; i < 32; i++) mem_a[i] = '0;
      for (int i = 0; i < 4; i++) mem_a[i] = mk_instr(OP_ADD, 27'(i + 10));
      mem_a[4]  = mk_instr(OP_HALT, 27'h15);
      jt_mask_a = '0;
   endtask

   bit         done;
   int         ne, nb, last_b, gap_bad;
   logic [2:0] pcs_b [12];
   logic [2:0] ret_b [12];

   initial begin
      sys_rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      load_straight();
      for (int i = 0; i < 8; i++) mem_b[i] = mk_instr(OP_ADD, 27'(i));
      repeat (3) @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);

      check("rst_pc",      32'(pc_a),      32'd0);
      check("rst_ir",      ir_a,           32'd0);
      check("rst_addr",    32'(addr_a),    32'd0);
      check("rst_flags",   32'({exec_a, busy_a, halted_a}), 32'd0);
      check("rst_retired", 32'(retired_a), 32'd0);

      // straight-line run to halt
      pulse_start_a();
      run_a(200, done);
      check("sl_done",    32'(done),      32'd1);
      check("sl_nexec",   32'(n_ex),      32'd5);
      check("sl_min_gap", 32'(min_gap),   32'd8);
      check("sl_max_gap", 32'(max_gap),   32'd8);
      check("sl_pc",      32'(pc_a),      32'd4);
      check("sl_addr",    32'(addr_a),    32'd4);
      check("sl_retired", 32'(retired_a), 32'd5);
      check("sl_ir",      ir_a,           mk_instr(OP_HALT, 27'h15));
      check("sl_busy",    32'(busy_a),    32'd0);
      for (int i = 0; i < 5; i++) check("sl_exec_pc", 32'(ex_pc[i]), 32'(i));

      // restart from HALT; halt word with a taken jump; start while busy ignored
      for (int i = 0; i < 32; i++) mem_a[i] = '0;
      mem_a[0]  = mk_instr(OP_ADD, 27'd1);
      mem_a[1]  = mk_instr(OP_SUB, 27'd2);
      mem_a[2]  = mk_instr(OP_HALT, 27'd9);
      jt_mask_a = 32'h0000_0007;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      check("rs_busy",    32'(busy_a),    32'd1);
      check("rs_halted",  32'(halted_a),  32'd0);
      check("rs_pc",      32'(pc_a),      32'd0);
      check("rs_retired", 32'(retired_a), 32'd0);
      repeat (10) @(negedge clk);
      check("sb_busy_at_start", 32'(busy_a), 32'd1);
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      run_a(200, done);
      check("hp_done",    32'(done),      32'd1);
      check("hp_pc",      32'(pc_a),      32'd2);
      check("hp_retired", 32'(retired_a), 32'd3);
      check("hp_ir",      ir_a,           mk_instr(OP_HALT, 27'd9));

      // jump loop, taken at address 6
      for (int i = 0; i < 32; i++) mem_a[i] = '0;
      mem_a[0]  = mk_instr(OP_JMP, 27'd6);
      mem_a[6]  = mk_instr(OP_JMP, 27'd4);
      mem_a[4]  = mk_instr(OP_HALT, 27'd0);
      mem_a[7]  = mk_instr(OP_HALT, 27'd1);
      jt_mask_a = 32'h0000_0041;
      pulse_start_a();
      run_a(200, done);
      check("jt_done",  32'(done),     32'd1);
      check("jt_nexec", 32'(n_ex),     32'd3);
      check("jt_pc1",   32'(ex_pc[1]), 32'd6);
      check("jt_pc2",   32'(ex_pc[2]), 32'd4);
      check("jt_pc",    32'(pc_a),     32'd4);

      // same code, jump at address 6 not taken
      jt_mask_a = 32'h0000_0001;
      pulse_start_a();
      run_a(200, done);
      check("jn_done",  32'(done),     32'd1);
      check("jn_pc2",   32'(ex_pc[2]), 32'd7);
      check("jn_pc",    32'(pc_a),     32'd7);
      check("jn_ir",    ir_a,          mk_instr(OP_HALT, 27'd1));

      // asynchronous reset in the third WAIT cycle of the second instruction
      load_straight();
      pulse_start_a();
      ne = 0;
      for (int c = 0; c < 100 && ne < 2; c++) begin
         @(negedge clk);
         if (exec_a) ne++;
      end
      check("rw_reach", 32'(ne), 32'd2);
      repeat (3) @(posedge clk);
      #2;
      check("rw_pre_pc",      32'(pc_a),      32'd1);
      check("rw_pre_retired", 32'(retired_a), 32'd1);
      check("rw_pre_busy",    32'(busy_a),    32'd1);
      sys_rst = 1'b1;
      #1;
      check("rw_pc",      32'(pc_a),      32'd0);
      check("rw_ir",      ir_a,           32'd0);
      check("rw_addr",    32'(addr_a),    32'd0);
      check("rw_flags",   32'({exec_a, busy_a, halted_a}), 32'd0);
      check("rw_retired", 32'(retired_a), 32'd0);
      @(negedge clk);
      sys_rst = 1'b0;
      ne = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (exec_a || busy_a) ne++;
      end
      check("rw_quiet", 32'(ne), 32'd0);

      // small build: 4-cycle period, pc wrap, retired saturation
      check("b_idle_retired", 32'(retired_b), 32'd0);
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      nb = 0; last_b = 0; gap_bad = 0;
      for (int c = 0; c < 200 && nb < 12; c++) begin
         @(negedge clk);
         if (exec_b) begin
            if (nb > 0 && (c - last_b) != 4) gap_bad++;
            pcs_b[nb] = pc_b;
            ret_b[nb] = retired_b;
            last_b = c;
            nb++;
         end
      end
      check("b_count",   32'(nb),       32'd12);
      check("b_gap_bad", 32'(gap_bad),  32'd0);
      check("b_pc6",     32'(pcs_b[6]), 32'd6);
      check("b_pc7",     32'(pcs_b[7]), 32'd7);
      check("b_pc8",     32'(pcs_b[8]), 32'd0);
      check("b_pc9",     32'(pcs_b[9]), 32'd1);
      check("b_ret5",    32'(ret_b[5]), 32'd5);
      check("b_ret7",    32'(ret_b[7]), 32'd7);
      check("b_ret11",   32'(ret_b[11]), 32'd7);
      check("b_busy",    32'(busy_b),   32'd1);
      check("b_halted",  32'(halted_b), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
